// File: rtl/uart_loop_pkg.sv
// Shared types and constants for the UART frame loopback engine.
// Imported by the interface, the frame FIFO and the top level.
package uart_loop_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PROC,
        PWAIT,
        SEND,
        WBUSY,
        WIDLE
    } state_t;

    localparam int DATA_W_DEF   = 64;
    localparam int DEPTH_DEF    = 4;
    localparam int PROC_EN_DEF  = 0;
    localparam int BUSY_TMO_DEF = 16;

    localparam logic [7:0] OVF_MAX = 8'd255;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == OVF_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_frame_loop_if.sv
// Transmit and processing-engine handshakes of the loopback engine.
// master = loopback side, slave = transmitter / engine side.
interface uart_frame_loop_if
    import uart_loop_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic              send_en;
    logic [DATA_W-1:0] send_data;
    logic              tx_busy;
    logic              proc_start;
    logic [DATA_W-1:0] proc_data;
    logic              proc_done;
    logic [DATA_W-1:0] proc_result;

    modport master (
        output send_en,
        output send_data,
        input  tx_busy,
        output proc_start,
        output proc_data,
        input  proc_done,
        input  proc_result
    );

    modport slave (
        input  send_en,
        input  send_data,
        output tx_busy,
        input  proc_start,
        input  proc_data,
        output proc_done,
        output proc_result
    );

endinterface

// File: rtl/uart_frame_loop_fifo.sv
// Frame FIFO: flop storage, head read straight from the storage flops.
// A push into a full FIFO is taken when a pop happens in the same cycle.
module frame_fifo
    import uart_loop_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        din,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[AW-1:0]];

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_frame_loop.sv
// Frame loopback engine: receiver -> FIFO -> optional engine -> transmitter.
// Frames keep arrival order; one frame is in flight at a time.
module uart_frame_loop
    import uart_loop_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int PROC_EN  = PROC_EN_DEF,
    parameter int BUSY_TMO = BUSY_TMO_DEF
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   recv_done,
    input  logic [DATA_W-1:0]      recv_data,
    uart_frame_loop_if.master      lnk,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [7:0]             ovf_cnt
);

    localparam logic [7:0] TMO_LAST = 8'(BUSY_TMO - 1);

    state_t            state;
    state_t            state_nx;
    logic [2:0]        sync_q;
    logic              recv_flag;
    logic [DATA_W-1:0] cur;
    logic [DATA_W-1:0] head;
    logic              full;
    logic              empty;
    logic              drop;
    logic [7:0]        tmo_cnt;
    logic              pop_go;
    logic              start_go;
    logic              res_go;
    logic              send_go;

    // recv_done is asynchronous: two flops, then a third for the edge
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) sync_q <= '0;
        else            sync_q <= {sync_q[1:0], recv_done};
    end

    assign recv_flag = sync_q[1] & ~sync_q[2];
    assign drop      = recv_flag && full && !pop_go;

    frame_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .push  (recv_flag),
        .din   (recv_data),
        .pop   (pop_go),
        .head  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        pop_go   = 1'b0;
        start_go = 1'b0;
        res_go   = 1'b0;
        send_go  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop_go   = 1'b1;
                    state_nx = (PROC_EN != 0) ? PROC : SEND;
                end
            end
            PROC: begin
                start_go = 1'b1;
                state_nx = PWAIT;
            end
            PWAIT: begin
                if (lnk.proc_done) begin
                    res_go   = 1'b1;
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (!lnk.tx_busy) begin
                    send_go  = 1'b1;
                    state_nx = WBUSY;
                end
            end
            // a transmitter that never answers must not stall the queue
            WBUSY: begin
                if (lnk.tx_busy)               state_nx = WIDLE;
                else if (tmo_cnt == TMO_LAST)  state_nx = IDLE;
            end
            WIDLE: begin
                if (!lnk.tx_busy) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cur            <= '0;
            tmo_cnt        <= '0;
            lnk.send_en    <= 1'b0;
            lnk.send_data  <= '0;
            lnk.proc_start <= 1'b0;
            lnk.proc_data  <= '0;
            ovf_cnt        <= '0;
        end else begin
            if (pop_go)      cur <= head;
            else if (res_go) cur <= lnk.proc_result;
            tmo_cnt        <= (state == WBUSY) ? tmo_cnt + 8'd1 : '0;
            lnk.send_en    <= send_go;
            lnk.proc_start <= start_go;
            if (send_go)  lnk.send_data <= cur;
            if (start_go) lnk.proc_data <= cur;
            if (drop)     ovf_cnt <= sat_inc(ovf_cnt);
        end
    end

endmodule

// File: tb/tb_uart_frame_loop.sv
// Bench for uart_frame_loop: bypass instance (a) and processing instance (b),
// transmitter/engine models and send-order scoreboards.
module tb_uart_frame_loop;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;
    logic        rdone_a, rdone_b;
    logic [63:0] rdata_a, rdata_b;
    logic [2:0]  lvl_a, lvl_b;
    logic [7:0]  ovf_a, ovf_b;

    int n_tests = 0;
    int n_fail  = 0;
    int sent_a  = 0;
    int sent_b  = 0;
    int s_cyc_a = 0;
    int p_cyc_a = 0;
    int rise_cyc = 0;
    int tx_mode_a = 0;
    int cnt_a = 0, cnt_b = 0;
    bit pend_a = 0, pend_b = 0;

    logic [63:0] exp_a[$];
    logic [63:0] exp_b[$];
    logic [63:0] exp_pd[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_frame_loop_if #(.DATA_W(64)) ifa ();
    uart_frame_loop_if #(.DATA_W(64)) ifb ();

    uart_frame_loop #(
        .DATA_W(64), .DEPTH(4), .PROC_EN(0), .BUSY_TMO(16)
    ) dut_a (
        .sys_clk    (clk),
        .sys_rst_n  (rst_n),
        .recv_done  (rdone_a),
        .recv_data  (rdata_a),
        .lnk        (ifa),
        .fifo_level (lvl_a),
        .ovf_cnt    (ovf_a)
    );

    uart_frame_loop #(
        .DATA_W(64), .DEPTH(4), .PROC_EN(1), .BUSY_TMO(16)
    ) dut_b (
        .sys_clk    (clk),
        .sys_rst_n  (rst_n),
        .recv_done  (rdone_b),
        .recv_data  (rdata_b),
        .lnk        (ifb),
        .fifo_level (lvl_b),
        .ovf_cnt    (ovf_b)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // transmitter a: mode 0 busy 20 cycles one cycle after send_en,
    // mode 1 busy stuck high, mode 2 busy never rises
    initial begin
        ifa.tx_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (tx_mode_a == 1) begin
                ifa.tx_busy = 1'b1; cnt_a = 0; pend_a = 0;
            end else if (tx_mode_a == 2) begin
                ifa.tx_busy = 1'b0; cnt_a = 0; pend_a = 0;
            end else begin
                if (pend_a) begin cnt_a = 20; pend_a = 0; end
                else if (cnt_a > 0) cnt_a--;
                if (ifa.send_en) pend_a = 1;
                ifa.tx_busy = (cnt_a > 0);
            end
        end
    end

    initial begin
        ifb.tx_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (pend_b) begin cnt_b = 20; pend_b = 0; end
            else if (cnt_b > 0) cnt_b--;
            if (ifb.send_en) pend_b = 1;
            ifb.tx_busy = (cnt_b > 0);
        end
    end

    // processing engine: input XOR ones, done 10 cycles after start
    initial begin
        logic [63:0] pd;
        ifa.proc_done   = 1'b0;
        ifa.proc_result = '0;
        ifb.proc_done   = 1'b0;
        ifb.proc_result = '0;
        forever begin
            @(posedge clk); #1;
            if (ifb.proc_start) begin
                pd = ifb.proc_data;
                repeat (10) @(posedge clk);
                #1;
                ifb.proc_result = pd ^ ONES;
                ifb.proc_done   = 1'b1;
                @(posedge clk); #1;
                ifb.proc_done   = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (ifa.send_en) begin
                sent_a++;
                p_cyc_a = s_cyc_a;
                s_cyc_a = cyc;
                if (exp_a.size() == 0) chk("a_unexp", 1, 0);
                else chk("a_send", ifa.send_data, exp_a.pop_front());
            end
            if (ifa.proc_start) chk("a_pstart", 1, 0);
            if (ifb.send_en) begin
                sent_b++;
                if (exp_b.size() == 0) chk("b_unexp", 1, 0);
                else chk("b_send", ifb.send_data, exp_b.pop_front());
            end
            if (ifb.proc_start) begin
                if (exp_pd.size() == 0) chk("b_punexp", 1, 0);
                else chk("b_pdata", ifb.proc_data, exp_pd.pop_front());
            end
        end
    end

    task automatic push(input bit b, input logic [63:0] d);
        @(posedge clk); #1;
        if (b) begin rdata_b = d; rdone_b = 1'b1; end
        else   begin rdata_a = d; rdone_a = 1'b1; end
        rise_cyc = cyc;
        repeat (2) @(posedge clk);
        #1;
        rdone_a = 1'b0;
        rdone_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic drain(input bit b, input int maxc);
        int n = 0;
        bit done_q = 0;
        while (n < maxc && !done_q) begin
            @(negedge clk);
            n++;
            if (b) done_q = exp_b.size() == 0 && lvl_b == 0 &&
                            cnt_b == 0 && !pend_b && !ifb.send_en;
            else   done_q = exp_a.size() == 0 && lvl_a == 0 &&
                            cnt_a == 0 && !pend_a && !ifa.send_en;
        end
        if (!done_q) chk(b ? "b_drain_tmo" : "a_drain_tmo", 0, 1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int n;
        logic [63:0] f [6];
        rst_n   = 1'b0;
        rdone_a = 1'b0;
        rdone_b = 1'b0;
        rdata_a = '0;
        rdata_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_send_en",   ifa.send_en, 0);
        chk("rst_send_data", ifa.send_data, 0);
        chk("rst_pstart",    ifa.proc_start, 0);
        chk("rst_pdata",     ifa.proc_data, 0);
        chk("rst_level",     lvl_a, 0);
        chk("rst_ovf",       ovf_a, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // bypass single frame, latency from recv_done rise
        s0 = sent_a;
        exp_a.push_back(64'h0123_4567_89AB_CDEF);
        push(0, 64'h0123_4567_89AB_CDEF);
        drain(0, 200);
        chk("byp_latency", s_cyc_a - rise_cyc, 5);
        chk("byp_count",   sent_a - s0, 1);
        chk("byp_level",   lvl_a, 0);

        // burst while busy
        tx_mode_a = 1;
        repeat (3) @(posedge clk);
        s0 = sent_a;
        for (int i = 0; i < 4; i++) begin
            f[i] = 64'hA000_0000_0000_0000 + 64'(i) * 64'h1111;
            exp_a.push_back(f[i]);
            push(0, f[i]);
        end
        chk("burst_level", lvl_a, 3);
        chk("burst_ovf",   ovf_a, 0);
        tx_mode_a = 0;
        drain(0, 400);
        chk("burst_count", sent_a - s0, 4);

        // overflow with the FSM parked in WIDLE, then counter saturation
        s0 = sent_a;
        exp_a.push_back(64'h5555_0000_0000_0001);
        push(0, 64'h5555_0000_0000_0001);
        n = 0;
        while (sent_a == s0 && n < 50) begin @(negedge clk); n++; end
        if (sent_a == s0) chk("ovf_first_send", 0, 1);
        tx_mode_a = 1;
        for (int i = 0; i < 6; i++) begin
            f[i] = 64'hB000_0000_0000_0000 + 64'(i + 1);
            if (i < 4) exp_a.push_back(f[i]);
            push(0, f[i]);
        end
        chk("ovf_level", lvl_a, 4);
        chk("ovf_cnt",   ovf_a, 2);
        for (int i = 0; i < 254; i++) push(0, 64'hDEAD_0000_0000_0000 + 64'(i));
        chk("ovf_sat",     ovf_a, 255);
        chk("ovf_level_2", lvl_a, 4);
        tx_mode_a = 0;
        drain(0, 400);
        chk("ovf_count", sent_a - s0, 5);

        // busy never rises: timeout then next frame
        tx_mode_a = 2;
        repeat (2) @(posedge clk);
        exp_a.push_back(64'hC0C0_0000_0000_0001);
        exp_a.push_back(64'hC0C0_0000_0000_0002);
        push(0, 64'hC0C0_0000_0000_0001);
        push(0, 64'hC0C0_0000_0000_0002);
        drain(0, 200);
        chk("tmo_gap", s_cyc_a - p_cyc_a, 18);
        tx_mode_a = 0;

        // processing mode
        s0 = sent_b;
        exp_pd.push_back(64'h0);
        exp_b.push_back(ONES);
        push(1, 64'h0);
        drain(1, 200);
        chk("proc_count", sent_b - s0, 1);
        chk("proc_pd_q",  exp_pd.size(), 0);

        // reset while waiting on the engine with 2 frames queued
        exp_pd.push_back(64'hA5A5_5A5A_0000_1111);
        push(1, 64'hA5A5_5A5A_0000_1111);
        push(1, 64'h2222_0000_0000_0002);
        push(1, 64'h3333_0000_0000_0003);
        chk("mid_level", lvl_b, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_b_send_en",   ifb.send_en, 0);
        chk("mid_b_send_data", ifb.send_data, 0);
        chk("mid_b_pstart",    ifb.proc_start, 0);
        chk("mid_b_pdata",     ifb.proc_data, 0);
        chk("mid_b_level",     lvl_b, 0);
        chk("mid_b_ovf",       ovf_b, 0);
        chk("mid_a_send_data", ifa.send_data, 0);
        chk("mid_a_ovf",       ovf_a, 0);
        chk("mid_a_level",     lvl_a, 0);
        exp_b.delete();
        exp_pd.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        s0 = sent_b;
        repeat (30) @(negedge clk);
        chk("mid_ghost_send", sent_b - s0, 0);
        chk("mid_post_level", lvl_b, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
